// File: rtl/cond_exec_ctrl.sv
// Execute-stage conditional execution controller: waits on the ALU, evaluates the ARM condition
// against the NZCV register, gates write enables and commits flags. COND_PERF_CNT_EN adds exec/squash counters.
module cond_exec_ctrl #(
    parameter int TIMEOUT_CYCLES = 16,
    parameter int CNT_W          = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       in_cond,
    input  logic [1:0]       in_flag_w,
    input  logic             in_reg_w,
    input  logic             in_mem_w,
    input  logic             in_pc_s,
    input  logic             alu_done,
    input  logic [3:0]       alu_flags,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_reg_w,
    output logic             out_mem_w,
    output logic             out_pc_s,
    output logic             out_cond_ex,
    output logic             out_flush,
    output logic [3:0]       flags,
    output logic             err,
    output logic [CNT_W-1:0] exec_cnt,
    output logic [CNT_W-1:0] squash_cnt
);
    typedef enum logic [1:0] {IDLE, WAIT_ALU, HOLD} state_t;

    localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    state_t        state, state_nxt;
    logic [3:0]    cond_q, alu_q;
    logic [1:0]    flag_w_q;
    logic          reg_w_q, mem_w_q, pc_s_q, cond_ex_q;
    logic [TW-1:0] tmo_cnt;
    logic          tmo_hit, capture, resolve, commit, hold;

    function automatic logic cond_eval(input logic [3:0] c, input logic [3:0] f);
        logic n, z, cf, v;
        {n, z, cf, v} = f;
        case (c)
            4'b0000: return z;
            4'b0001: return !z;
            4'b0010: return cf;
            4'b0011: return !cf;
            4'b0100: return n;
            4'b0101: return !n;
            4'b0110: return v;
            4'b0111: return !v;
            4'b1000: return cf && !z;
            4'b1001: return !cf || z;
            4'b1010: return n == v;
            4'b1011: return n != v;
            4'b1100: return !z && (n == v);
            4'b1101: return z || (n != v);
            4'b1110: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    // alu_done on the last allowed cycle wins over the timeout
    assign tmo_hit = (TIMEOUT_CYCLES != 0) && !alu_done &&
                     (tmo_cnt == TW'(TIMEOUT_CYCLES - 1));

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        capture   = 1'b0;
        resolve   = 1'b0;
        commit    = 1'b0;
        out_flush = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    capture   = 1'b1;
                    state_nxt = WAIT_ALU;
                end
            end
            WAIT_ALU: begin
                if (alu_done || tmo_hit) begin
                    resolve   = 1'b1;
                    state_nxt = HOLD;
                end
            end
            HOLD: begin
                if (out_ready) begin
                    commit = 1'b1;
                    if (pc_s_q && cond_ex_q) begin
                        out_flush = 1'b1;
                        state_nxt = IDLE;
                    end else begin
                        in_ready = 1'b1;
                        if (in_valid) begin
                            capture   = 1'b1;
                            state_nxt = WAIT_ALU;
                        end else begin
                            state_nxt = IDLE;
                        end
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
        if (rst) in_ready = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cond_q    <= '0;
            alu_q     <= '0;
            flag_w_q  <= '0;
            reg_w_q   <= 1'b0;
            mem_w_q   <= 1'b0;
            pc_s_q    <= 1'b0;
            cond_ex_q <= 1'b0;
            tmo_cnt   <= '0;
            flags     <= '0;
            err       <= 1'b0;
        end else begin
            state <= state_nxt;
            if (capture) begin
                cond_q   <= in_cond;
                flag_w_q <= in_flag_w;
                reg_w_q  <= in_reg_w;
                mem_w_q  <= in_mem_w;
                pc_s_q   <= in_pc_s;
                tmo_cnt  <= '0;
            end else if (state == WAIT_ALU) begin
                tmo_cnt <= tmo_cnt + 1'b1;
            end
            // a timed-out instruction resolves as squashed
            if (resolve) begin
                alu_q     <= alu_flags;
                cond_ex_q <= alu_done && cond_eval(cond_q, flags);
                if (tmo_hit) err <= 1'b1;
            end
            if (commit && cond_ex_q) begin
                if (flag_w_q[1]) flags[3:2] <= alu_q[3:2];
                if (flag_w_q[0]) flags[1:0] <= alu_q[1:0];
            end
        end
    end

    assign hold        = (state == HOLD);
    assign out_valid   = hold;
    assign out_cond_ex = hold && cond_ex_q;
    assign out_reg_w   = hold && cond_ex_q && reg_w_q;
    assign out_mem_w   = hold && cond_ex_q && mem_w_q;
    assign out_pc_s    = hold && cond_ex_q && pc_s_q;

`ifdef COND_PERF_CNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            exec_cnt   <= '0;
            squash_cnt <= '0;
        end else if (commit) begin
            if (cond_ex_q) exec_cnt   <= exec_cnt + 1'b1;
            else           squash_cnt <= squash_cnt + 1'b1;
        end
    end
`else
    assign exec_cnt   = '0;
    assign squash_cnt = '0;
`endif

endmodule

// File: tb/tb_cond_exec_ctrl.sv
// Directed bench for cond_exec_ctrl: condition-table vectors plus backpressure, branch flush,
// timeout and asynchronous reset sequences.
module tb_cond_exec_ctrl;
    localparam int CNT_W = 32;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             in_valid = 1'b0, in_ready;
    logic [3:0]       in_cond = '0;
    logic [1:0]       in_flag_w = '0;
    logic             in_reg_w = 1'b0, in_mem_w = 1'b0, in_pc_s = 1'b0;
    logic             alu_done = 1'b0;
    logic [3:0]       alu_flags = '0;
    logic             out_valid, out_ready = 1'b0;
    logic             out_reg_w, out_mem_w, out_pc_s, out_cond_ex, out_flush;
    logic [3:0]       flags;
    logic             err;
    logic [CNT_W-1:0] exec_cnt, squash_cnt;

    cond_exec_ctrl #(.TIMEOUT_CYCLES(4), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_cond(in_cond), .in_flag_w(in_flag_w),
        .in_reg_w(in_reg_w), .in_mem_w(in_mem_w), .in_pc_s(in_pc_s),
        .alu_done(alu_done), .alu_flags(alu_flags),
        .out_valid(out_valid), .out_ready(out_ready), .out_reg_w(out_reg_w), .out_mem_w(out_mem_w),
        .out_pc_s(out_pc_s), .out_cond_ex(out_cond_ex), .out_flush(out_flush),
        .flags(flags), .err(err), .exec_cnt(exec_cnt), .squash_cnt(squash_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] cond;
        logic [1:0] fw;
        logic       rw, mw, ps;
        logic [3:0] alu;
        logic       ex;   // expected condition result
        logic [3:0] fl;   // expected flags after commit
    } vec_t;

    vec_t vecs[16];
    int   checks = 0, errors = 0;
    int   m_exec = 0, m_squash = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_cnts(input string nm);
`ifdef COND_PERF_CNT_EN
        chk({nm, "_exec"}, exec_cnt, m_exec);
        chk({nm, "_squash"}, squash_cnt, m_squash);
`else
        chk({nm, "_exec"}, exec_cnt, 0);
        chk({nm, "_squash"}, squash_cnt, 0);
`endif
    endtask

    task automatic drive(input logic [3:0] c, input logic [1:0] fw, input logic rw, input logic mw,
                         input logic ps);
        in_valid = 1'b1; in_cond = c; in_flag_w = fw;
        in_reg_w = rw; in_mem_w = mw; in_pc_s = ps;
    endtask

    task automatic alu_pulse(input logic [3:0] f);
        alu_done = 1'b1; alu_flags = f;
        step();
        alu_done = 1'b0; alu_flags = 4'hx;
    endtask

    initial begin
        logic [3:0] prev;
        vecs[0]  = '{4'b1110, 2'b11, 1'b0, 1'b0, 1'b0, 4'b0100, 1'b1, 4'b0100};
        vecs[1]  = '{4'b0000, 2'b00, 1'b1, 1'b0, 1'b0, 4'b0000, 1'b1, 4'b0100};
        vecs[2]  = '{4'b0001, 2'b11, 1'b1, 1'b1, 1'b0, 4'b1000, 1'b0, 4'b0100};
        vecs[3]  = '{4'b1110, 2'b11, 1'b0, 1'b0, 1'b0, 4'b1000, 1'b1, 4'b1000};
        vecs[4]  = '{4'b1011, 2'b00, 1'b1, 1'b0, 1'b0, 4'b0000, 1'b1, 4'b1000};
        vecs[5]  = '{4'b1100, 2'b00, 1'b1, 1'b0, 1'b0, 4'b0000, 1'b0, 4'b1000};
        vecs[6]  = '{4'b1110, 2'b11, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b1, 4'b0000};
        vecs[7]  = '{4'b1100, 2'b00, 1'b1, 1'b0, 1'b0, 4'b0000, 1'b1, 4'b0000};
        vecs[8]  = '{4'b1111, 2'b11, 1'b1, 1'b1, 1'b0, 4'b1111, 1'b0, 4'b0000};
        vecs[9]  = '{4'b0010, 2'b01, 1'b0, 1'b0, 1'b0, 4'b0010, 1'b0, 4'b0000};
        vecs[10] = '{4'b1110, 2'b01, 1'b0, 1'b0, 1'b0, 4'b0011, 1'b1, 4'b0011};
        vecs[11] = '{4'b1000, 2'b00, 1'b0, 1'b1, 1'b0, 4'b0000, 1'b1, 4'b0011};
        vecs[12] = '{4'b1001, 2'b00, 1'b0, 1'b1, 1'b0, 4'b0000, 1'b0, 4'b0011};
        vecs[13] = '{4'b1110, 2'b10, 1'b0, 1'b0, 1'b0, 4'b1111, 1'b1, 4'b1111};
        vecs[14] = '{4'b1101, 2'b00, 1'b1, 1'b0, 1'b0, 4'b0000, 1'b1, 4'b1111};
        vecs[15] = '{4'b1111, 2'b00, 1'b0, 1'b0, 1'b1, 4'b0000, 1'b0, 4'b1111};

        // reset state
        #2;
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_flags", flags, 0);
        chk("rst_err", err, 0);
        step(); step();
        rst = 1'b0;
        #1;
        chk("idle_in_ready", in_ready, 1);
        chk_cnts("rst");

        // condition table: capture, alu_done next cycle, HOLD the cycle after, commit
        prev = 4'b0000;
        for (int i = 0; i < 16; i++) begin
            drive(vecs[i].cond, vecs[i].fw, vecs[i].rw, vecs[i].mw, vecs[i].ps);
            step();
            in_valid = 1'b0;
            chk($sformatf("v%0d_wait_ready", i), in_ready, 0);
            chk($sformatf("v%0d_wait_valid", i), out_valid, 0);
            alu_pulse(vecs[i].alu);
            chk($sformatf("v%0d_valid", i), out_valid, 1);
            chk($sformatf("v%0d_cond_ex", i), out_cond_ex, vecs[i].ex);
            chk($sformatf("v%0d_reg_w", i), out_reg_w, vecs[i].rw & vecs[i].ex);
            chk($sformatf("v%0d_mem_w", i), out_mem_w, vecs[i].mw & vecs[i].ex);
            chk($sformatf("v%0d_pc_s", i), out_pc_s, vecs[i].ps & vecs[i].ex);
            chk($sformatf("v%0d_flags_pre", i), flags, prev);
            out_ready = 1'b1;
            #1;
            chk($sformatf("v%0d_commit_ready", i), in_ready, 1);
            chk($sformatf("v%0d_flush", i), out_flush, 0);
            step();
            out_ready = 1'b0;
            if (vecs[i].ex) m_exec++; else m_squash++;
            chk($sformatf("v%0d_idle_valid", i), out_valid, 0);
            chk($sformatf("v%0d_flags", i), flags, vecs[i].fl);
            prev = vecs[i].fl;
        end
        chk_cnts("table");

        // backpressure, then back-to-back: EQ must see Z from the new flags (0000), not the old 1111
        drive(4'b1110, 2'b11, 1'b1, 1'b0, 1'b0);
        step();
        in_valid = 1'b0;
        alu_pulse(4'b0000);
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("bp%0d_valid", k), out_valid, 1);
            chk($sformatf("bp%0d_reg_w", k), out_reg_w, 1);
            chk($sformatf("bp%0d_ready", k), in_ready, 0);
            chk($sformatf("bp%0d_flags", k), flags, 4'b1111);
            step();
        end
        out_ready = 1'b1;
        drive(4'b0000, 2'b00, 1'b1, 1'b0, 1'b0);
        #1;
        chk("b2b_in_ready", in_ready, 1);
        step();
        m_exec++;
        out_ready = 1'b0; in_valid = 1'b0;
        chk("b2b_flags", flags, 4'b0000);
        chk("b2b_wait_valid", out_valid, 0);
        chk("b2b_wait_ready", in_ready, 0);
        alu_pulse(4'b0100);
        chk("b2b_cond_ex", out_cond_ex, 0);
        chk("b2b_reg_w", out_reg_w, 0);
        out_ready = 1'b1;
        step();
        m_squash++;
        out_ready = 1'b0;
        chk_cnts("b2b");

        // taken branch: flush only in the commit cycle, no capture that cycle
        drive(4'b1110, 2'b11, 1'b0, 1'b0, 1'b1);
        step();
        in_valid = 1'b0;
        alu_pulse(4'b1010);
        chk("br_pc_s", out_pc_s, 1);
        chk("br_flush_stall", out_flush, 0);
        out_ready = 1'b1;
        drive(4'b1110, 2'b00, 1'b1, 1'b0, 1'b0);
        #1;
        chk("br_flush", out_flush, 1);
        chk("br_in_ready", in_ready, 0);
        step();
        m_exec++;
        out_ready = 1'b0; in_valid = 1'b0;
        #1;
        chk("br_after_flush", out_flush, 0);
        chk("br_after_valid", out_valid, 0);
        chk("br_after_idle", in_ready, 1);
        chk("br_flags", flags, 4'b1010);

        // timeout: 4 cycles in WAIT_ALU without alu_done squashes and sets err
        drive(4'b1110, 2'b11, 1'b1, 1'b1, 1'b0);
        step();
        in_valid = 1'b0;
        for (int k = 0; k < 3; k++) step();
        chk("tmo_err_early", err, 0);
        chk("tmo_valid_early", out_valid, 0);
        step();
        m_squash++;
        chk("tmo_err", err, 1);
        chk("tmo_valid", out_valid, 1);
        chk("tmo_cond_ex", out_cond_ex, 0);
        chk("tmo_reg_w", out_reg_w, 0);
        step();
        chk("tmo_err_sticky", err, 1);
        chk("tmo_hold_stable", out_valid, 1);

        // async reset while in HOLD, between clock edges
        #2;
        rst = 1'b1;
        #1;
        chk("arst_valid", out_valid, 0);
        chk("arst_mem_w", out_mem_w, 0);
        chk("arst_flags", flags, 0);
        chk("arst_err", err, 0);
        chk("arst_in_ready", in_ready, 0);
        m_exec = 0; m_squash = 0;
        chk_cnts("arst");
        step();
        rst = 1'b0;
        #1;
        chk("post_rst_idle", in_ready, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/cond_exec_ctrl.md
Name: cond_exec_ctrl

Overview:
Sequences conditional execution for the core's Execute stage. It accepts one decoded instruction at a time and waits for the multi-cycle ALU to finish. It then evaluates the instruction's 4-bit condition against the architectural NZCV flag register, gates the write enables, and updates the flags at commit. It holds the NZCV register, so downstream logic never sees a stale flag value.

Parameters:
TIMEOUT_CYCLES, 16, max cycles in WAIT_ALU before err is set; 0 disables the timeout
CNT_W, 32, width of the performance counters (see Optional Feature)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous active-high reset
in_valid  in  1  decoded instruction offered
in_ready  out  1  controller accepts instruction
in_cond  in  4  ARM condition field
in_flag_w  in  2  [1]: update N,Z; [0]: update C,V
in_reg_w  in  1  instruction writes the register file
in_mem_w  in  1  instruction writes memory
in_pc_s  in  1  instruction writes PC (branch)
alu_done  in  1  one-cycle pulse: ALU result for the captured instruction is ready
alu_flags  in  4  {N,Z,C,V} from the ALU, valid with alu_done
out_valid  out  1  gated controls valid
out_ready  in  1  downstream accepts
out_reg_w  out  1  in_reg_w AND cond_ex
out_mem_w  out  1  in_mem_w AND cond_ex
out_pc_s  out  1  in_pc_s AND cond_ex
out_cond_ex  out  1  condition result
out_flush  out  1  pulse on commit of a taken branch
flags  out  4  architectural {N,Z,C,V}
err  out  1  sticky ALU timeout
exec_cnt  out  CNT_W  executed-instruction count
squash_cnt  out  CNT_W  squashed-instruction count

Behaviour:
- Reset (async, rst=1):
  - state=IDLE; flags=0000; err=0; counters=0.
  - All out_* = 0; in_ready=0 while rst is high.
- States:
  - IDLE: in_ready=1. in_valid=1 captures cond, flag_w, reg_w, mem_w, pc_s → WAIT_ALU.
  - WAIT_ALU: in_ready=0. alu_done=1 → evaluate cond against the flags register, latch alu_flags and cond_ex → HOLD.
    - alu_done is ignored in IDLE/HOLD.
    - alu_done is sampled only in WAIT_ALU, so minimum latency is capture at cycle t, alu_done at t+1, out_valid at t+2.
  - HOLD: out_valid=1, outputs stable until out_ready. Commit = out_valid & out_ready. At commit:
    - If cond_ex: flag_w[1] loads N,Z from the latched alu_flags[3:2]; flag_w[0] loads C,V from [1:0].
    - If !cond_ex: flags unchanged.
    - Taken branch (pc_s & cond_ex): out_flush=1 for that cycle, in_ready=0, → IDLE.
    - Otherwise in_ready=out_ready. A simultaneous in_valid captures the next instruction → WAIT_ALU, else → IDLE.
- Back-to-back: the next instruction's condition is evaluated in WAIT_ALU, after the previous commit, so it always sees the updated flags.
- Condition table (N,Z,C,V):
  - 0000 EQ Z; 0001 NE !Z; 0010 CS C; 0011 CC !C.
  - 0100 MI N; 0101 PL !N; 0110 VS V; 0111 VC !V.
  - 1000 HI C&!Z; 1001 LS !C|Z.
  - 1010 GE N==V; 1011 LT N!=V; 1100 GT !Z&(N==V); 1101 LE Z|(N!=V).
  - 1110 AL 1; 1111 → 0 (never).
- Timeout:
  - A counter runs in WAIT_ALU and clears on entry.
  - Reaching TIMEOUT_CYCLES without alu_done sets err=1 (sticky until rst) and forces → HOLD with cond_ex=0, i.e. the instruction is squashed.
- out_* are registered; no combinational path from in_* to out_*. in_ready may depend combinationally on out_ready.

Optional Feature:
- Macro: COND_PERF_CNT_EN.
- Defined:
  - At each commit, exec_cnt increments if cond_ex=1, else squash_cnt increments.
  - Counters wrap at 2^CNT_W; rst clears them.
- Undefined: exec_cnt and squash_cnt are tied to 0 and no counter flops are built.

Test Plan:
- EQ with Z set:
  - Stimulus: reset, commit CMP-like (cond=1110, flag_w=11, alu_flags=0100), then cond=0000 reg_w=1.
  - Expect: flags=0100 after the first commit; second instruction gives out_cond_ex=1, out_reg_w=1.
- NE squash:
  - Stimulus: with flags=0100, issue cond=0001 reg_w=1 mem_w=1 flag_w=11 alu_flags=1000.
  - Expect: out_cond_ex=0, out_reg_w=0, out_mem_w=0, flags stay 0100; squash_cnt=1 when the macro is defined.
- LT/GT:
  - Stimulus: with flags=1000, issue cond=1011, then cond=1100.
  - Expect: 1, then 0. With flags=0000: cond=1100 → 1.
- Backpressure and back-to-back:
  - Stimulus: hold out_ready=0 for 3 cycles in HOLD, then out_ready=1 with in_valid=1.
  - Expect: outputs stable during the stall; the second instruction is captured in the commit cycle and its condition uses the newly committed flags.
- Taken branch:
  - Stimulus: cond=1110 pc_s=1.
  - Expect: out_pc_s=1; out_flush=1 for exactly the commit cycle; in_ready=0 that cycle; IDLE next cycle.
- Timeout and reset mid-operation:
  - Stimulus: TIMEOUT_CYCLES=4, never pulse alu_done.
  - Expect: err=1 after 4 cycles in WAIT_ALU, instruction squashed. Then assert rst in HOLD: all outputs 0, flags=0000, err=0 immediately (asynchronously).
